fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-PC fetch stage.
- Decouples instruction memory latency from decode: runs ahead of decode, holding up to DEPTH fetched instructions, each tagged with its PC and PC+INSTR_BYTES, in an internal queue.
- Handles variable-latency memory through a rd/done/stall handshake, redirects (branch/jump) with flush and squash of an in-flight read, and a sticky memory error.
- Sits between the PC-redirect logic of execute and the fetch/decode pipeline register.

Parameters:
- DATA_W, 16, instruction width.
- ADDR_W, 16, PC/address width.
- DEPTH, 4, queue entries; power of two, >= 2.
- INSTR_BYTES, 2, PC increment per sequential fetch.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  discard queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  target PC.
- deq_stall  in  1  decode cannot accept this cycle (includes nop insertion).
- imem_rd  out  1  read request.
- imem_addr  out  ADDR_W  read address.
- imem_data  in  DATA_W  read data; valid when imem_done.
- imem_done  in  1  read complete this cycle.
- imem_stall  in  1  memory busy (observability only; request is held regardless).
- imem_err  in  1  memory error, sampled with imem_done or imem_rd.
- out_valid  out  1  head entry valid.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- out_pc_next  out  ADDR_W  head PC + INSTR_BYTES.
- err  out  1  sticky error.

Behaviour:
- Reset (sync, high):
  - fetch_pc=RESET_PC; queue empty; state=IDLE.
  - imem_rd=0; out_valid=0; out_instr/out_pc/out_pc_next=0; err=0.
  - Reset asserted mid-transaction drops it. The memory shares rst, so no squash is carried across reset.
- Dequeue:
  - Occurs when out_valid && !deq_stall.
  - Head outputs are registered queue contents. No combinational path from imem_data to out_*; minimum fill-to-visible latency is 1 cycle.
- Memory handshake:
  - imem_rd is held high with imem_addr constant from issue until the cycle imem_done=1. That cycle completes the read.
  - imem_done with imem_rd=0 is ignored.
- States:
  - IDLE: imem_rd=0.
    - -> REQ when credits>0 && !redirect_valid && !err, with imem_addr=fetch_pc.
    - credits = DEPTH - count.
  - REQ: imem_rd=1.
    - On imem_done without redirect: push {imem_data, fetch_pc, fetch_pc+INSTR_BYTES}; fetch_pc += INSTR_BYTES.
      - Then -> REQ (back-to-back, new address next cycle) if space remains after this cycle's push/pop, else -> IDLE.
    - On redirect_valid without done: -> SQUASH; address stays held.
    - On redirect_valid with done: data discarded -> IDLE.
  - SQUASH: imem_rd=1 at old address; data discarded on imem_done -> IDLE.
    - Further redirects in SQUASH only update fetch_pc.
  - ERR: imem_rd=0; terminal until rst.
- Redirect (any state):
  - Queue flushed: count=0, out_valid=0 next cycle.
  - fetch_pc <= redirect_pc.
  - A dequeue in the same cycle is ignored; redirect wins.
  - A push in the same cycle is suppressed.
- Full / empty:
  - Issue only if count < DEPTH at issue, counting the reserved slot, so a push never overflows.
  - Simultaneous push+pop keeps count unchanged.
  - Pop on empty is impossible, since out_valid=0.
- Arithmetic:
  - PCs wrap modulo 2^ADDR_W (0xFFFE+2=0x0000), no flag.
  - Read/write pointers wrap modulo DEPTH; count is $clog2(DEPTH+1) bits.
- Error:
  - imem_err with imem_done in REQ sets err and goes to ERR. The entry is not pushed.
  - Queued entries remain dequeueable. Redirect still flushes but does not leave ERR.
  - imem_err in SQUASH is ignored.

Decomposition:
- Shared package:
  - fetch state enum (IDLE, REQ, SQUASH, ERR).
  - queue-entry struct {instr, pc, pc_next}.
  - INSTR_BYTES and RESET_PC defaults.
- One natural sub-module: fetch_fifo. A DEPTH x entry synchronous FIFO with push/pop/flush, count, full/empty, and registered head.

Test Plan:
- Reset then zero-latency memory (done same cycle as rd), deq_stall=0 -> imem_addr 0,2,4,... on consecutive cycles; out_pc 0,2,4 one cycle behind; out_pc_next=out_pc+2.
- deq_stall=1 held, DEPTH=4 -> exactly 4 reads (0,2,4,6), imem_rd then 0. Release deq_stall -> entries 0..6 in order, then fetch resumes at 8.
- 3-cycle memory; redirect_valid with redirect_pc=0x0040 during the 2nd wait cycle of read 0x0004 -> addr held at 0x0004 until done, data dropped. Next read at 0x0040; first out_pc=0x0040; no 0x0004 entry.
- Redirect in the same cycle as imem_done and a dequeue -> queue empty next cycle; next imem_addr=redirect_pc; popped and returned data both discarded.
- fetch_pc=0xFFFC -> entries 0xFFFC, 0xFFFE, 0x0000 with out_pc_next 0xFFFE, 0x0000, 0x0002.
- imem_err with done at 0x0006 after 3 entries queued -> err=1 stays set, imem_rd=0 forever. The 3 entries still dequeue; rst clears err and restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch queue: fetch FSM states and queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_INSTR_BYTES = 2;
  localparam int unsigned DEF_RESET_PC    = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SQUASH = 2'd2,
    ST_ERR    = 2'd3
  } fetch_state_e;

  // Default-width queue entry; the top re-declares it at its own parameter widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] pc_next;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO with flush and a registered head entry.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fq_entry_t,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             valid,
  output entry_t           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_d;
  entry_t           head_d;

  // Next pointer/count and next head: a push into an otherwise empty queue bypasses into head.
  always_comb begin
    rd_ptr_d = rd_ptr;
    count_d  = count;
    head_d   = head;
    if (flush) begin
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr + PTR_W'(1);
      end
      count_d = count + CNT_W'(push) - CNT_W'(pop);
      if (push && ((count - CNT_W'(pop)) == '0)) begin
        head_d = push_data;
      end else if (pop) begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
      full   <= (count_d == CNT_W'(DEPTH));
      valid  <= (count_d != '0);
      head   <= head_d;
      if (flush) begin
        wr_ptr <= '0;
      end else if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Run-ahead instruction fetch: issues memory reads into a small queue feeding decode,
// with redirect flush/squash and a sticky memory error.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              deq_stall,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_done,
  input  logic              imem_stall,
  input  logic              imem_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
  } entry_t;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_q;
  logic              rd_d;
  logic              err_q;
  logic              err_d;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pc_plus;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_valid;
  entry_t            push_entry;
  entry_t            head;

  // Memory busy is informational only; the request is held until done either way.
  logic unused_stall;
  assign unused_stall = imem_stall;

  assign pc_plus    = fetch_pc_q + PC_STEP;
  assign push_entry = '{instr: imem_data, pc: fetch_pc_q, pc_next: pc_plus};
  assign pop        = fifo_valid && !deq_stall && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= ADDR_W'(RESET_PC);
      addr_q     <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Next state; a redirect always retargets fetch_pc and suppresses any push this cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    err_d      = err_q;
    push       = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_full && !redirect_valid && !err_q) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          state_d = imem_done ? ST_IDLE : ST_SQUASH;
        end else if (imem_done) begin
          if (imem_err) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            push       = 1'b1;
            fetch_pc_d = pc_plus;
            // Chain the next read only if the queue still has a free slot after this push.
            if (pop || (fifo_count != CNT_W'(DEPTH - 1))) begin
              state_d = ST_REQ;
              addr_d  = pc_plus;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_SQUASH: begin
        if (imem_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rd_d = (state_d == ST_REQ) || (state_d == ST_SQUASH);
  end

  fetch_queue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .full      (fifo_full),
    .valid     (fifo_valid),
    .head      (head)
  );

  assign imem_rd     = rd_q;
  assign imem_addr   = addr_q;
  assign out_valid   = fifo_valid;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_pc_next = head.pc_next;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: transaction-level queue model, reactive memory, directed and random runs.
module tb_fetch_queue;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_next;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        deq_stall = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        imem_done = 1'b0;
  logic        imem_stall = 1'b0;
  logic        imem_err = 1'b0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_next;
  logic        err;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_stall      (deq_stall),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_done      (imem_done),
    .imem_stall     (imem_stall),
    .imem_err       (imem_err),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_next    (out_pc_next),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Model state: queue contents, the one outstanding read, and sticky error.
  ent_t        q[$];
  logic [15:0] m_pc = '0;
  logic [15:0] m_addr = '0;
  bit          m_reading = 0;
  bit          m_sq = 0;
  bit          m_err = 0;
  int          m_wait = 0;
  int          m_lat = 0;
  int          n_push = 0;
  logic [15:0] seen_pc[$];
  logic [15:0] seen_nx[$];

  // Stimulus knobs.
  int lat_fixed = 0;
  int err_addr = -1;
  int err_pct = 0;
  bit spurious = 0;
  bit cmp_en = 0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model, advanced on each rising edge from the inputs the bench presented.
  always @(posedge clk) begin
    bit pop, push, was_reading, done_now;
    int pre_size;
    if (rst) begin
      q.delete();
      m_pc = 16'h0000;
      m_addr = '0;
      m_reading = 0;
      m_sq = 0;
      m_err = 0;
      m_wait = 0;
      n_push = 0;
    end else begin
      pre_size = q.size();
      was_reading = m_reading;
      done_now = m_reading && imem_done;
      push = 0;
      pop = (q.size() > 0) && !deq_stall && !redirect_valid;
      if (pop) begin
        seen_pc.push_back(q[0].pc);
        seen_nx.push_back(q[0].pc_next);
        void'(q.pop_front());
      end
      if (redirect_valid) q.delete();
      if (done_now) begin
        m_reading = 0;
        if (!m_sq && !redirect_valid) begin
          if (imem_err) m_err = 1;
          else begin
            q.push_back('{instr: imem_data, pc: m_addr, pc_next: 16'(m_addr + 16'd2)});
            m_pc = 16'(m_addr + 16'd2);
            push = 1;
            n_push++;
          end
        end
        m_sq = 0;
      end else if (m_reading) begin
        m_wait++;
        if (redirect_valid) m_sq = 1;
      end
      if (redirect_valid) m_pc = redirect_pc;
      // Issue: chained after a good completion if room remains, else from idle if not full.
      if (!m_err && !redirect_valid && !m_reading &&
          ((push && q.size() < 4) || (!was_reading && pre_size < 4))) begin
        m_reading = 1;
        m_addr = m_pc;
        m_wait = 0;
        m_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(3, 0));
      end
    end
  end

  // Memory responder: completes the model's outstanding read after its latency.
  always @(negedge clk) begin
    if (m_reading) begin
      imem_done = (m_wait >= m_lat);
      imem_stall = !imem_done;
      imem_data = 16'($urandom);
      imem_err = (imem_done && ((err_addr >= 0 && m_addr == 16'(err_addr)) ||
                                (int'($urandom_range(99, 0)) < err_pct))) ||
                 (!imem_done && spurious && ($urandom_range(1, 0) == 1));
    end else begin
      imem_stall = 1'b0;
      imem_done = spurious && ($urandom_range(3, 0) == 0);
      imem_data = 16'($urandom);
      imem_err = spurious && ($urandom_range(1, 0) == 1);
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_rd", 32'(imem_rd), 32'(m_reading));
      if (m_reading) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_instr", 32'(out_instr), 32'(q[0].instr));
        chk("out_pc", 32'(out_pc), 32'(q[0].pc));
        chk("out_pc_next", 32'(out_pc_next), 32'(q[0].pc_next));
      end
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic chk_seen(input string name, input int idx, input logic [15:0] exp_pc,
                          input logic [15:0] exp_nx);
    if (idx < seen_pc.size()) begin
      chk({name, "_pc"}, 32'(seen_pc[idx]), 32'(exp_pc));
      chk({name, "_next"}, 32'(seen_nx[idx]), 32'(exp_nx));
    end else begin
      chk({name, "_missing"}, 32'(seen_pc.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    bit found;
    int cnt4;
    @(negedge clk);
    // Reset state, then zero-latency streaming.
    rst = 1'b1;
    lat_fixed = 0;
    @(negedge clk);
    cmp_en = 1;
    chk("rst_rd", 32'(imem_rd), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", 32'(out_instr), 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_pc_next", 32'(out_pc_next), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rd", 32'(imem_rd), 1);
    chk("t1_addr0", 32'(imem_addr), 32'h0);
    @(negedge clk);
    chk("t1_addr1", 32'(imem_addr), 32'h2);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_pc0", 32'(out_pc), 32'h0);
    chk("t1_nx0", 32'(out_pc_next), 32'h2);
    @(negedge clk);
    chk("t1_addr2", 32'(imem_addr), 32'h4);
    chk("t1_pc1", 32'(out_pc), 32'h2);

    // Decode stalled: exactly DEPTH reads, then drain in order and resume.
    deq_stall = 1'b1;
    do_reset();
    repeat (12) @(negedge clk);
    chk("t2_reads", 32'(n_push), 4);
    chk("t2_rd_idle", 32'(imem_rd), 0);
    chk("t2_head", 32'(out_pc), 32'h0);
    seen_pc.delete();
    seen_nx.delete();
    deq_stall = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) chk_seen($sformatf("t2_pop%0d", i), i, 16'(2 * i), 16'(2 * i + 2));

    // Redirect during the second wait cycle of the read at 0x0004 (3-cycle memory).
    lat_fixed = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (imem_rd && imem_addr == 16'h0004 && m_wait == 1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t3_reach", 32'(found), 1);
    seen_pc.delete();
    seen_nx.delete();
    redirect_pulse(16'h0040);
    chk("t3_hold_rd", 32'(imem_rd), 1);
    chk("t3_hold_addr", 32'(imem_addr), 32'h4);
    for (int i = 0; i < 40 && seen_pc.size() == 0; i++) @(negedge clk);
    chk_seen("t3_first", 0, 16'h0040, 16'h0042);
    cnt4 = 0;
    foreach (seen_pc[i]) if (seen_pc[i] == 16'h0004) cnt4++;
    chk("t3_no_0004", 32'(cnt4), 0);

    // Redirect coinciding with a completion and a dequeue.
    lat_fixed = 0;
    do_reset();
    repeat (5) @(negedge clk);
    chk("t4_pre", 32'({imem_rd, out_valid}), 32'h3);
    seen_pc.delete();
    seen_nx.delete();
    redirect_pulse(16'h0100);
    chk("t4_empty", 32'(out_valid), 0);
    chk("t4_idle", 32'(imem_rd), 0);
    @(negedge clk);
    chk("t4_rd", 32'(imem_rd), 1);
    chk("t4_addr", 32'(imem_addr), 32'h0100);
    repeat (3) @(negedge clk);
    chk_seen("t4_first", 0, 16'h0100, 16'h0102);

    // PC wrap across 0xFFFE -> 0x0000.
    deq_stall = 1'b1;
    do_reset();
    redirect_pulse(16'hFFFC);
    repeat (10) @(negedge clk);
    seen_pc.delete();
    seen_nx.delete();
    deq_stall = 1'b0;
    repeat (4) @(negedge clk);
    chk_seen("t5_e0", 0, 16'hFFFC, 16'hFFFE);
    chk_seen("t5_e1", 1, 16'hFFFE, 16'h0000);
    chk_seen("t5_e2", 2, 16'h0000, 16'h0002);

    // Memory error at 0x0006 after three queued entries.
    deq_stall = 1'b1;
    err_addr = 6;
    do_reset();
    repeat (12) @(negedge clk);
    chk("t6_err", 32'(err), 1);
    chk("t6_rd", 32'(imem_rd), 0);
    chk("t6_head", 32'(out_pc), 32'h0);
    seen_pc.delete();
    seen_nx.delete();
    deq_stall = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_npops", 32'(seen_pc.size()), 3);
    for (int i = 0; i < 3; i++) chk_seen($sformatf("t6_pop%0d", i), i, 16'(2 * i), 16'(2 * i + 2));
    chk("t6_drained", 32'(out_valid), 0);
    redirect_pulse(16'h0020);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 1);
    chk("t6_rd_dead", 32'(imem_rd), 0);
    err_addr = -1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_err_clr", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_restart_rd", 32'(imem_rd), 1);
    chk("t6_restart_addr", 32'(imem_addr), 32'h0);

    // Randomised traffic: variable latency, stalls, redirects, stray done/err.
    lat_fixed = -1;
    spurious = 1;
    for (int r = 0; r < 4; r++) begin
      err_pct = (r == 3) ? 1 : 0;
      deq_stall = 1'b0;
      do_reset();
      repeat (400) begin
        deq_stall = ($urandom_range(99, 0) < 35);
        if ($urandom_range(99, 0) < 5) begin
          redirect_valid = 1'b1;
          redirect_pc = 16'($urandom) & 16'hFFFE;
        end else begin
          redirect_valid = 1'b0;
        end
        @(negedge clk);
      end
      redirect_valid = 1'b0;
    end
    spurious = 0;
    err_pct = 0;
    deq_stall = 1'b0;
    @(negedge clk);
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
